// File: rtl/lbp_pkg.sv
// Shared constants, state encoding and uniform-pattern helper for the LBP histogram stage.
// Pure declarations; no timing or flow control of its own.
package lbp_pkg;

   localparam int LBP_CNT_W      = 14;
   localparam int LBP_NPIX       = 15876;
   localparam int LBP_NBINS_FULL = 256;
   localparam int LBP_NBINS_UNI  = 59;

   typedef enum logic [1:0] {
      ST_ACC,
      ST_LOAD,
      ST_DRAIN,
      ST_DONE
   } lbp_state_t;

   // Number of circular 0/1 transitions in an 8-bit LBP code.
   function automatic int lbp_transitions(input logic [7:0] code);
      return $countones(code ^ {code[0], code[7:1]});
   endfunction

endpackage

// File: rtl/lbp_uniform_map.sv
// Combinational LBP code -> uniform-pattern index (0..57 uniform in code order, 58 otherwise).
// Zero latency, no flow control.
module lbp_uniform_map
   import lbp_pkg::*;
(
   input  logic [7:0] i_code,
   output logic [5:0] o_idx
);

   function automatic logic [5:0] uniform_idx(input int code);
      int n;
      n = 0;
      if (lbp_transitions(8'(code)) > 2) return 6'd58;
      for (int c = 0; c < code; c++) begin
         if (lbp_transitions(8'(c)) <= 2) n++;
      end
      return 6'(n);
   endfunction

   logic [5:0] w_lut [256];

   // Table is built from constants, so it folds to a fixed 256-entry ROM.
   for (genvar g = 0; g < 256; g++) begin : g_lut
      assign w_lut[g] = uniform_idx(g);
   end

   assign o_idx = w_lut[i_code];

endmodule

// File: rtl/lbp_hist.sv
// Per-frame LBP code histogram, drained bin by bin on finish; LBP_HIST_UNIFORM_EN selects 59 uniform bins.
// Samples land in bins on the sampling edge; drain gives one bin per cycle and holds outputs while hist_ready is low.
module lbp_hist
   import lbp_pkg::*;
#(
   parameter int CNT_W = LBP_CNT_W,
   parameter int NPIX  = LBP_NPIX
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             lbp_valid,
   input  logic [7:0]       lbp_data,
   input  logic             finish,
   output logic             hist_valid,
   input  logic             hist_ready,
   output logic [7:0]       hist_bin,
   output logic [CNT_W-1:0] hist_count,
   output logic             hist_done,
   output logic             hist_err
);

`ifdef LBP_HIST_UNIFORM_EN
   localparam int NBINS = LBP_NBINS_UNI;
`else
   localparam int NBINS = LBP_NBINS_FULL;
`endif
   localparam int IDX_W  = $clog2(NBINS);
   localparam int SAMP_W = CNT_W + 1;
   localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [SAMP_W-1:0] SAMP_MAX = {SAMP_W{1'b1}};

   lbp_state_t        r_state;
   lbp_state_t        w_state_nxt;
   logic [CNT_W-1:0]  r_bins [NBINS];
   logic [SAMP_W-1:0] r_samp;
   logic              r_hist_valid;
   logic [7:0]        r_hist_bin;
   logic [CNT_W-1:0]  r_hist_count;
   logic              r_hist_done;
   logic              r_hist_err;

   logic [IDX_W-1:0]  w_idx;
   logic [IDX_W-1:0]  w_next_idx;
   logic              w_hs;
   logic              w_last;

`ifdef LBP_HIST_UNIFORM_EN
   lbp_uniform_map u_map (
      .i_code (lbp_data),
      .o_idx  (w_idx)
   );
`else
   assign w_idx = lbp_data;
`endif

   assign w_hs       = r_hist_valid & hist_ready;
   assign w_last     = (r_hist_bin == 8'(NBINS - 1));
   assign w_next_idx = r_hist_bin[IDX_W-1:0] + 1'b1;

   always_ff @(posedge clk) begin
      if (!reset) r_state <= ST_ACC;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_ACC:   if (finish) w_state_nxt = ST_LOAD;
         ST_LOAD:  w_state_nxt = ST_DRAIN;
         ST_DRAIN: if (w_hs && w_last) w_state_nxt = ST_DONE;
         default:  w_state_nxt = r_state;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < NBINS; i++) r_bins[i] <= '0;
         r_samp       <= '0;
         r_hist_valid <= 1'b0;
         r_hist_bin   <= '0;
         r_hist_count <= '0;
         r_hist_done  <= 1'b0;
         r_hist_err   <= 1'b0;
      end else begin
         case (r_state)
            ST_ACC: begin
               // Single-cycle read-modify-write, so back-to-back hits on one bin need no forwarding.
               if (lbp_valid) begin
                  if (r_bins[w_idx] != CNT_MAX) r_bins[w_idx] <= r_bins[w_idx] + 1'b1;
                  if (r_samp != SAMP_MAX)       r_samp <= r_samp + 1'b1;
               end
            end
            ST_LOAD: begin
               r_hist_valid <= 1'b1;
               r_hist_bin   <= '0;
               r_hist_count <= r_bins[0];
            end
            ST_DRAIN: begin
               if (w_hs) begin
                  if (w_last) begin
                     r_hist_valid <= 1'b0;
                     r_hist_done  <= 1'b1;
                     r_hist_err   <= (r_samp != SAMP_W'(NPIX));
                  end else begin
                     r_hist_bin   <= r_hist_bin + 8'd1;
                     r_hist_count <= r_bins[w_next_idx];
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign hist_valid = r_hist_valid;
   assign hist_bin   = r_hist_bin;
   assign hist_count = r_hist_count;
   assign hist_done  = r_hist_done;
   assign hist_err   = r_hist_err;

endmodule

// File: tb/tb_lbp_hist.sv
// Scoreboard bench for lbp_hist: a reference histogram predicts every drained bin and the frame error flag.
module tb_lbp_hist;
   import lbp_pkg::*;

`ifdef LBP_HIST_UNIFORM_EN
   localparam int NB = 59;
`else
   localparam int NB = 256;
`endif
   localparam int CW    = 14;
   localparam int NP    = 15876;
   localparam int CMAX  = (1 << CW) - 1;
   localparam int SMAX  = (1 << (CW + 1)) - 1;
   localparam int ABORT = (NB > 100) ? 100 : 40;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          lbp_valid = 1'b0;
   logic [7:0]    lbp_data = 8'd0;
   logic          finish = 1'b0;
   logic          hist_ready = 1'b0;
   logic          hist_valid;
   logic [7:0]    hist_bin;
   logic [CW-1:0] hist_count;
   logic          hist_done;
   logic          hist_err;

   lbp_hist #(.CNT_W(CW), .NPIX(NP)) dut (
      .clk        (clk),
      .reset      (reset),
      .lbp_valid  (lbp_valid),
      .lbp_data   (lbp_data),
      .finish     (finish),
      .hist_valid (hist_valid),
      .hist_ready (hist_ready),
      .hist_bin   (hist_bin),
      .hist_count (hist_count),
      .hist_done  (hist_done),
      .hist_err   (hist_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int bin;
      int cnt;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   mbins[NB];
   int   msamp;
   bit   exp_err;

   task automatic check(input string name, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

`ifdef LBP_HIST_UNIFORM_EN
   int ucodes[$];

   function automatic bit is_uniform(input int code);
      int t = 0;
      for (int b = 0; b < 8; b++)
         if (code[b] != code[(b + 1) % 8]) t++;
      return t <= 2;
   endfunction
`endif

   function automatic int model_idx(input int code);
`ifdef LBP_HIST_UNIFORM_EN
      foreach (ucodes[i]) if (ucodes[i] == code) return i;
      return 58;
`else
      return code;
`endif
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      foreach (mbins[i]) mbins[i] = 0;
      msamp = 0;
   endtask

   task automatic push_expect();
      for (int b = 0; b < NB; b++) sb.push_back('{b, mbins[b]});
      exp_err = (msamp != NP);
   endtask

   task automatic send(input int code, input bit fin);
      int k;
      lbp_valid = 1'b1;
      lbp_data  = 8'(code);
      finish    = fin;
      k = model_idx(code);
      if (mbins[k] < CMAX) mbins[k]++;
      if (msamp < SMAX) msamp++;
      if (fin) push_expect();
      step();
      lbp_valid = 1'b0;
      finish    = 1'b0;
   endtask

   task automatic fin_only();
      finish = 1'b1;
      push_expect();
      step();
      finish = 1'b0;
   endtask

   task automatic do_reset();
      reset      = 1'b0;
      hist_ready = 1'b0;
      step();
      step();
      reset = 1'b1;
      model_clear();
   endtask

   // mode 0: ready high; 1: ready toggles; 2: random ready plus ignored junk on lbp_valid/finish.
   task automatic drain(input int mode, input int abort_bin);
      bit done_seen = 1'b0;
      for (int cyc = 0; cyc < 4000 && !done_seen; cyc++) begin
         case (mode)
            0:       hist_ready = 1'b1;
            1:       hist_ready = cyc[0];
            default: hist_ready = 1'($urandom_range(0, 1));
         endcase
         if (mode == 2) begin
            lbp_valid = 1'($urandom_range(0, 1));
            lbp_data  = 8'($urandom_range(0, 255));
            finish    = ($urandom_range(0, 3) == 0);
         end
         step();
         lbp_valid = 1'b0;
         finish    = 1'b0;
         if (abort_bin >= 0 && hist_valid && hist_bin == 8'(abort_bin)) begin
            reset      = 1'b0;
            hist_ready = 1'b0;
            step();
            check("rst_valid", hist_valid, 0);
            check("rst_bin", hist_bin, 0);
            check("rst_count", hist_count, 0);
            check("rst_done", hist_done, 0);
            check("rst_err", hist_err, 0);
            reset = 1'b1;
            return;
         end
         done_seen = hist_done;
      end
      check("drain_done", hist_done, 1);
      check("hist_err", hist_err, exp_err);
      check("valid_after_done", hist_valid, 0);
      check("bins_left", sb.size(), 0);
      hist_ready = 1'b0;
   endtask

   // Monitor: pops one expected bin per handshake, checks stall stability.
   initial begin
      bit         prev_stall = 1'b0;
      logic [7:0] prev_bin   = 8'd0;
      logic [CW-1:0] prev_cnt = '0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset) begin
            sb.delete();
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               check("stall_valid", hist_valid, 1);
               check("stall_bin", hist_bin, prev_bin);
               check("stall_count", hist_count, prev_cnt);
            end
            if (hist_valid && hist_ready) begin
               if (sb.size() == 0) begin
                  check("unexpected_bin", hist_bin, -1);
               end else begin
                  e = sb.pop_front();
                  check("bin_idx", hist_bin, e.bin);
                  check("bin_cnt", hist_count, e.cnt);
               end
            end
            prev_stall = hist_valid && !hist_ready;
            prev_bin   = hist_bin;
            prev_cnt   = hist_count;
         end
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1);
   end

   initial begin
`ifdef LBP_HIST_UNIFORM_EN
      for (int c = 0; c < 256; c++) if (is_uniform(c)) ucodes.push_back(c);
`endif
      model_clear();
      step();
      step();
      check("reset_valid", hist_valid, 0);
      check("reset_bin", hist_bin, 0);
      check("reset_count", hist_count, 0);
      check("reset_done", hist_done, 0);
      check("reset_err", hist_err, 0);
      reset = 1'b1;
      step();

      // Full frame of i%256, exact NPIX count.
      for (int i = 0; i < NP; i++) send(i % 256, 1'b0);
      fin_only();
      drain(0, -1);
      do_reset();

      // Ten back-to-back hits on one code, drained with a toggling ready.
      repeat (10) send(8'h5A, 1'b0);
      fin_only();
      drain(1, -1);
      do_reset();

      // Random codes with gaps, last sample coincides with finish.
      repeat (600) begin
         send($urandom_range(0, 255), 1'b0);
         repeat ($urandom_range(0, 2)) step();
      end
      send(8'h03, 1'b1);
      drain(2, -1);
      do_reset();

      // Reset mid-drain, then a new frame must start from empty bins.
      repeat (300) send($urandom_range(0, 255), 1'b0);
      fin_only();
      drain(0, ABORT);
      model_clear();
      send(8'h05, 1'b0);
      send(8'h06, 1'b0);
      send(8'hFF, 1'b0);
      fin_only();
      drain(0, -1);
      do_reset();

      // Saturation of a single bin.
      repeat (CMAX + 7) send(8'h00, 1'b0);
      fin_only();
      drain(1, -1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/lbp_hist.md
# lbp_hist

Histogram stage directly downstream of the LBP feature-extraction engine. Consumes the LBP output stream (valid / 8-bit code) and accumulates a per-code occurrence histogram over one frame. On the engine's finish pulse it drains the histogram bin by bin over a valid/ready interface to the classifier or host. It then flags completion and whether the frame held the expected pixel count.

## Interface
- CNT_W, 14: bin counter width; max per-bin count is 2^CNT_W-1.
- NPIX, 15876: expected LBP samples per frame (126×126 interior pixels).
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-low; clears all state and bins.
- lbp_valid  in  1  one-cycle strobe: lbp_data is a new code.
- lbp_data  in  8  LBP code.
- finish  in  1  frame-complete pulse from the LBP engine.
- hist_valid  out  1  hist_bin/hist_count hold a bin.
- hist_ready  in  1  consumer accepts the current bin.
- hist_bin  out  8  bin index, 0..NBINS-1.
- hist_count  out  CNT_W  count for hist_bin.
- hist_done  out  1  drain complete; held until reset.
- hist_err  out  1  valid in DONE; 1 if accepted samples ≠ NPIX.

## Operation
- NBINS = 256; 59 with uniform mapping (see Configuration). Bins are a register array of NBINS×CNT_W.
- States: ACC → LOAD → DRAIN → DONE. Reset (reset==0) forces ACC from any state, mid-drain included.
- ACC: each cycle with lbp_valid=1, bin[idx(lbp_data)] += 1, saturating at 2^CNT_W-1. Sample counter (CNT_W+1 bits, saturating) increments. Back-to-back hits on the same bin count correctly; single-cycle read-modify-write, no hazard.
- ACC: finish=1 → LOAD. A lbp_valid in the same cycle as finish is still accumulated.
- LOAD: one cycle. Registers hist_bin=0, hist_count=bin[0], hist_valid=1. Goes to DRAIN.
- DRAIN: the handshake completes on hist_valid&hist_ready. On completion with hist_bin<NBINS-1: hist_bin+1, hist_count=bin[hist_bin+1]. On completion at NBINS-1: hist_valid=0, hist_done=1, hist_err=(sample count≠NPIX), → DONE. While hist_valid&!hist_ready, all outputs stay stable.
- lbp_valid and finish are ignored outside ACC.
- DONE: terminal. Bins are not cleared; only reset starts a new frame.
- Reset values: hist_valid=0, hist_bin=0, hist_count=0, hist_done=0, hist_err=0, all bins=0, sample counter=0.

## Timing
- Accumulate latency: a bin reflects a sample on the edge that samples lbp_valid.
- finish sampled at edge k: LOAD during cycle k..k+1. hist_valid=1 from edge k+1.
- With hist_ready held high, one bin per cycle: NBINS bins in NBINS cycles. hist_done rises on the edge after the last accepted bin.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- LBP_HIST_UNIFORM_EN defined: idx maps each code to the rotation-invariant-free uniform scheme, NBINS=59. The 58 codes with ≤2 circular 0/1 transitions get indices 0..57 in ascending code order. All other codes map to 58. Examples: 0x00→0, 0x01→1, 0x04→4, 0x05→58, 0x06→5, 0xFF→57.
- Undefined: idx = lbp_data, NBINS=256.

## Structure
- Shared package lbp_pkg holds: state encoding (ACC, LOAD, DRAIN, DONE), default NPIX, CNT_W, and the NBINS constants for both configurations.
- One sub-module, lbp_uniform_map: combinational 8-bit code → 6-bit index. It is instantiated only when LBP_HIST_UNIFORM_EN is defined.

## Test plan
- Stream of 15876 codes with value i%256, then finish, hist_ready=1. Bins 0..3 read 63, bins 4..255 read 62; hist_done=1; hist_err=0.
- 10 back-to-back lbp_valid with code 0x5A, then finish. bin 0x5A=10, all others 0; hist_err=1.
- hist_ready toggled 0/1 every other cycle during drain. Each bin is presented exactly once, with outputs stable while stalled; 256 handshakes total.
- CNT_W=4: 20 samples of code 0x00. bin[0] saturates at 15.
- lbp_valid with code 0x03 in the same cycle as finish. bin[3]=1 at readout.
- reset=0 asserted mid-drain at bin 100. All outputs are 0 next cycle; a new frame accumulates from cleared bins.
- With LBP_HIST_UNIFORM_EN: codes 0x05, 0x06, 0xFF, then finish. 59 bins drained; bin58=1, bin5=1, bin57=1.
